// File: rtl/reg_write_buffer.sv
// reg_write_buffer: in-order FIFO of pending regfile writes with youngest-match lookup forwarding
module reg_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [4:0]  in_addr,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        commit_stall,
    output logic        wr_en,
    output logic [4:0]  wr_addr,
    output logic [31:0] wr_data,
    input  logic [4:0]  lookup_addr_1,
    input  logic [4:0]  lookup_addr_2,
    output logic        hit_1,
    output logic        hit_2,
    output logic [31:0] hit_data_1,
    output logic [31:0] hit_data_2,
    output logic [3:0]  count,
    output logic        empty,
    output logic        full
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0]    head_q, head_d, tail_q, tail_d, idx;
    logic [3:0]       count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [4:0]       addr_q [DEPTH];
    logic [4:0]       addr_d [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [31:0]      data_d [DEPTH];
    logic             accept, commit;
    always_comb begin
        count = count_q;
        full = count_q == 4'(DEPTH);
        empty = count_q == 4'd0;
        commit = !rst && !empty && !commit_stall;
        in_ready = !rst && (!full || commit);
        accept = in_valid && in_ready && in_addr != 5'd0;
        wr_en = commit;
        wr_addr = addr_q[head_q];
        wr_data = data_q[head_q];
        head_d = commit ? head_q + AW'(1) : head_q;
        tail_d = accept ? tail_q + AW'(1) : tail_q;
        count_d = count_q + 4'(accept) - 4'(commit);
        valid_d = valid_q;
        addr_d = addr_q;
        data_d = data_q;
        if (commit) valid_d[head_q] = 1'b0;
        if (accept) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
        end
        hit_1 = 1'b0;
        hit_2 = 1'b0;
        hit_data_1 = 32'd0;
        hit_data_2 = 32'd0;
        idx = '0;
        // walk oldest to youngest so the youngest match is the one left standing
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + AW'(i);
            if (valid_q[idx] && lookup_addr_1 != 5'd0 && addr_q[idx] == lookup_addr_1) begin
                hit_1 = 1'b1;
                hit_data_1 = data_q[idx];
            end
            if (valid_q[idx] && lookup_addr_2 != 5'd0 && addr_q[idx] == lookup_addr_2) begin
                hit_2 = 1'b1;
                hit_data_2 = data_q[idx];
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_reg_write_buffer.sv
// tb_reg_write_buffer: random and directed stimulus checked against a queue model of the write buffer
module tb_reg_write_buffer;
    localparam int DEPTH = 4;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, commit_stall = 1'b0;
    logic [4:0]  in_addr = '0, lookup_addr_1 = '0, lookup_addr_2 = '0;
    logic [31:0] in_data = '0;
    logic        in_ready, wr_en, hit_1, hit_2, empty, full;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data, hit_data_1, hit_data_2;
    logic [3:0]  count;
    int n_vec = 0, n_err = 0;
    logic [36:0] q[$];

    reg_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data),
        .in_ready(in_ready), .commit_stall(commit_stall), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .lookup_addr_1(lookup_addr_1), .lookup_addr_2(lookup_addr_2),
        .hit_1(hit_1), .hit_2(hit_2), .hit_data_1(hit_data_1), .hit_data_2(hit_data_2),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
        h = 1'b0;
        d = 32'd0;
        if (a != 5'd0)
            for (int i = q.size() - 1; i >= 0; i--)
                if (q[i][36:32] == a) begin
                    h = 1'b1;
                    d = q[i][31:0];
                    break;
                end
    endfunction

    // model: the queue holds pending writes oldest-first; outputs follow from it and the inputs
    initial begin
        int sz;
        logic ecommit, efull, eready, eacc, h;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            #2;
            sz = q.size();
            efull = sz == DEPTH;
            ecommit = !rst && sz > 0 && !commit_stall;
            eready = !rst && (!efull || ecommit);
            eacc = in_valid && eready && in_addr != 5'd0;
            chk("in_ready", 32'(in_ready), 32'(eready));
            chk("wr_en", 32'(wr_en), 32'(ecommit));
            if (ecommit) begin
                chk("wr_addr", 32'(wr_addr), 32'(q[0][36:32]));
                chk("wr_data", wr_data, q[0][31:0]);
            end
            chk("count", 32'(count), sz);
            chk("empty", 32'(empty), 32'(sz == 0));
            chk("full", 32'(full), 32'(efull));
            lookup(lookup_addr_1, h, d);
            chk("hit_1", 32'(hit_1), 32'(h));
            chk("hit_data_1", hit_data_1, d);
            lookup(lookup_addr_2, h, d);
            chk("hit_2", 32'(hit_2), 32'(h));
            chk("hit_data_2", hit_data_2, d);
            @(posedge clk);
            if (rst) q.delete();
            else begin
                if (ecommit) void'(q.pop_front());
                if (eacc) q.push_back({in_addr, in_data});
            end
        end
    end

    task automatic drv(input logic r, input logic v, input logic [4:0] a, input logic [31:0] dat, input logic s);
        @(negedge clk);
        rst = r;
        in_valid = v;
        in_addr = a;
        in_data = dat;
        commit_stall = s;
    endtask

    initial begin
        int sent;
        @(negedge clk);
        #3 chk("rst_empty", 32'(empty), 1);
        chk("rst_count", 32'(count), 0);
        drv(1, 0, 0, 0, 0);
        // single write
        drv(0, 1, 5, 32'hDEADBEEF, 0);
        drv(0, 0, 0, 0, 0);
        #3 chk("single_wr_en", 32'(wr_en), 1);
        chk("single_wr_addr", 32'(wr_addr), 5);
        chk("single_wr_data", wr_data, 32'hDEADBEEF);
        drv(0, 0, 0, 0, 0);
        #3 chk("single_empty", 32'(empty), 1);
        // fill under stall, then release with the fifth still offered
        for (int k = 1; k <= 4; k++) drv(0, 1, 5'(k), 32'(k * 16), 1);
        drv(0, 1, 5, 32'h50, 1);
        #3 chk("fill_full", 32'(full), 1);
        chk("fill_ready", 32'(in_ready), 0);
        drv(0, 1, 5, 32'h50, 0);
        #3 chk("release_ready", 32'(in_ready), 1);
        chk("release_wr_addr", 32'(wr_addr), 1);
        for (int k = 2; k <= 5; k++) begin
            drv(0, 0, 0, 0, 0);
            #3 chk("commit_order", 32'(wr_addr), k);
        end
        drv(0, 0, 0, 0, 0);
        // forwarding picks the youngest match
        drv(0, 1, 7, 32'h11, 1);
        drv(0, 1, 7, 32'h22, 1);
        drv(0, 0, 0, 0, 1);
        lookup_addr_1 = 7;
        lookup_addr_2 = 8;
        #3 chk("fwd_hit_1", 32'(hit_1), 1);
        chk("fwd_data_1", hit_data_1, 32'h22);
        chk("fwd_hit_2", 32'(hit_2), 0);
        chk("fwd_data_2", hit_data_2, 0);
        repeat (3) drv(0, 0, 0, 0, 0);
        // zero register is consumed but dropped
        drv(0, 1, 0, 32'hFFFFFFFF, 0);
        lookup_addr_1 = 0;
        #3 chk("zero_ready", 32'(in_ready), 1);
        chk("zero_hit", 32'(hit_1), 0);
        drv(0, 0, 0, 0, 0);
        #3 chk("zero_count", 32'(count), 0);
        chk("zero_wr_en", 32'(wr_en), 0);
        // back-to-back writes with alternating stall, holding the request when refused
        sent = 0;
        for (int c = 0; c < 40 && sent < 10; c++) begin
            drv(0, 1, 5'(sent + 1), 32'(sent + 100), c[0]);
            #3 if (in_ready) sent++;
            chk("wrap_count_max", 32'(count <= 4'd4), 1);
        end
        chk("wrap_sent", sent, 10);
        repeat (8) drv(0, 0, 0, 0, 0);
        #3 chk("wrap_drained", 32'(empty), 1);
        // reset with three entries pending
        for (int k = 1; k <= 3; k++) drv(0, 1, 5'(k + 20), 32'(k), 1);
        drv(1, 1, 9, 32'h99, 0);
        drv(0, 0, 0, 0, 0);
        #3 chk("midrst_count", 32'(count), 0);
        chk("midrst_empty", 32'(empty), 1);
        chk("midrst_wr_en", 32'(wr_en), 0);
        // random traffic with address collisions and occasional reset
        for (int c = 0; c < 3000; c++) begin
            drv($urandom_range(0, 99) == 0, 1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                $urandom_range(0, 2) == 0);
            lookup_addr_1 = 5'($urandom_range(0, 7));
            lookup_addr_2 = 5'($urandom_range(0, 7));
        end
        drv(0, 0, 0, 0, 0);
        @(negedge clk);
        #3 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_write_buffer.md
REG_WRITE_BUFFER -- requirements
Module: RegWriteBuffer

Interface
REQ-001 SHALL declare parameter DEPTH, default 4, meaning number of pending-write entries (power of two, 2..8).
REQ-002 SHALL declare port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL declare port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL declare port in_valid  input  1  producer (MEM/WB stage) offers a register write.
REQ-005 SHALL declare port in_addr  input  5  destination register address (`REG_ADDR_BUS).
REQ-006 SHALL declare port in_data  input  32  write data (`DATA_BUS).
REQ-007 SHALL declare port in_ready  output  1  buffer accepts the offered write this cycle.
REQ-008 SHALL declare port commit_stall  input  1  regfile write port unavailable this cycle.
REQ-009 SHALL declare port wr_en  output  1  regfile write strobe.
REQ-010 SHALL declare port wr_addr  output  5  regfile write address.
REQ-011 SHALL declare port wr_data  output  32  regfile write data.
REQ-012 SHALL declare ports lookup_addr_1, lookup_addr_2  input  5 each  ID-stage read addresses to check.
REQ-013 SHALL declare ports hit_1, hit_2  output  1 each  pending write matches lookup address.
REQ-014 SHALL declare ports hit_data_1, hit_data_2  output  32 each  data of matching pending write, 0 when no hit.
REQ-015 SHALL declare ports count  output  4  occupied entries; empty, full  output  1 each.

Function
REQ-016 SHALL store writes as a circular FIFO: head (oldest), tail (next free), count; pointers wrap modulo DEPTH.
REQ-017 SHALL define accept = in_valid && in_ready && (in_addr != 0); an in_valid write to address 0 with in_ready high SHALL be consumed and discarded, not enqueued.
REQ-018 SHALL define commit = !empty && !commit_stall; wr_en = commit, with wr_addr/wr_data driven from head entry combinationally.
REQ-019 SHALL drive in_ready = !rst && (!full || commit), so a full buffer accepts when its head commits in the same cycle.
REQ-020 SHALL on accept write entry at tail and advance tail; on commit advance head; count += accept - commit.
REQ-021 SHALL give enqueue-to-commit latency of exactly 1 cycle minimum: entry accepted in cycle N appears on wr_* no earlier than cycle N+1 (no same-cycle bypass to wr_*).
REQ-022 SHALL commit entries strictly in acceptance order, one per cycle at most.
REQ-023 SHALL hold head entry and wr_en=0 while commit_stall=1; wr_addr/wr_data SHALL remain head values.
REQ-024 SHALL compute hit_k combinationally over all occupied entries, including the head committing this cycle; an entry being accepted this cycle SHALL NOT hit until the next cycle.
REQ-025 SHALL return the youngest matching occupied entry on multiple matches.
REQ-026 SHALL force hit_k=0, hit_data_k=0 when lookup_addr_k == 0.
REQ-027 SHALL assert empty iff count==0, full iff count==DEPTH.
REQ-028 SHALL leave FIFO state unchanged when in_valid=1 and in_ready=0 (producer must hold request).

Reset
REQ-029 SHALL on rst=1 at a clock edge set head=0, tail=0, count=0, clear all entry valids; empty=1, full=0, wr_en=0, hit_1=hit_2=0 from the next cycle.
REQ-030 SHALL hold in_ready=0 while rst=1, and SHALL discard any in-flight entries when rst is asserted mid-operation (no commit after reset).
REQ-031 SHALL ignore in_valid during the reset cycle.

Verification
REQ-032 Single write: in_valid=1, addr=5, data=0xDEADBEEF at cycle 0 -> cycle 1 wr_en=1, wr_addr=5, wr_data=0xDEADBEEF; cycle 2 empty=1.
REQ-033 Fill/stall: commit_stall=1, offer 5 writes to regs 1..5 -> first 4 accepted, full=1, in_ready=0 for 5th; release stall -> same cycle in_ready=1, 5th accepted, commits in order 1,2,3,4,5.
REQ-034 Forwarding: stalled buffer holds reg 7=0x11 then reg 7=0x22; lookup_addr_1=7 -> hit_1=1, hit_data_1=0x22; lookup_addr_2=8 -> hit_2=0, hit_data_2=0.
REQ-035 Zero register: offer addr=0 data=0xFFFFFFFF -> in_ready=1, count stays 0, wr_en never asserted; lookup_addr_1=0 -> hit_1=0.
REQ-036 Wrap-around: 10 back-to-back writes with alternating commit_stall -> pointers wrap, no loss or reorder, count never exceeds 4.
REQ-037 Reset mid-operation: 3 entries pending, rst=1 one cycle -> next cycle count=0, empty=1, wr_en=0, none of the 3 entries ever committed.
